// File: rtl/spi_arbiter.sv
// spi_arbiter: two-requester Avalon-MM arbiter in front of one shared soft-SPI
// slave. One requester owns the slave at a time. Ownership ends when the owner
// writes the release pattern (addr 2, data[2:0] = 3'b111), or when the owner stays
// quiet for TIMEOUT cycles. On that timeout the arbiter issues the release write
// itself. Address 3 is a local status register that returns the current grant.

module spi_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        reset_n,

  input  logic [1:0]  avs_s0_address,
  input  logic        avs_s0_read,
  input  logic        avs_s0_write,
  input  logic [31:0] avs_s0_writedata,
  output logic [31:0] avs_s0_readdata,
  output logic        avs_s0_waitrequest,

  input  logic [1:0]  avs_s1_address,
  input  logic        avs_s1_read,
  input  logic        avs_s1_write,
  input  logic [31:0] avs_s1_writedata,
  output logic [31:0] avs_s1_readdata,
  output logic        avs_s1_waitrequest,

  output logic [1:0]  avm_m0_address,
  output logic        avm_m0_read,
  output logic        avm_m0_write,
  output logic [31:0] avm_m0_writedata,
  input  logic [31:0] avm_m0_readdata,

  output logic [1:0]  grant
);

  // Arbiter states
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN0  = 2'd1;
  localparam logic [1:0] ST_OWN1  = 2'd2;
  localparam logic [1:0] ST_FORCE = 2'd3;

  // Address map
  localparam logic [1:0] ADDR_CTRL  = 2'd2;
  localparam logic [1:0] ADDR_LOCAL = 2'd3;

  // Last idle-count value tolerated before the forced release
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 32'd1);

  // Release pattern: a control-register write whose low three bits are all ones
  function automatic logic is_release(input logic        wr,
                                      input logic [1:0]  addr,
                                      input logic [31:0] wdata);
    is_release = wr && (addr == ADDR_CTRL) && (wdata[2:0] == 3'b111);
  endfunction

  logic [1:0]  state_q, state_d;
  logic        last_q, last_d;      // 1'b0 = s0 granted last, 1'b1 = s1
  logic [15:0] cnt_q, cnt_d;

  logic        s0_req_s, s1_req_s;  // request that targets the slave (addr 0-2)
  logic        s0_lrd_s, s1_lrd_s;  // local status read (addr 3)
  logic        fwd0_s, fwd1_s;      // owner access passed through this cycle
  logic        release_s;
  logic [1:0]  grant_s;

  // Decode requests and the forwarding condition from the current state
  always_comb begin
    s0_req_s  = (avs_s0_read | avs_s0_write) & (avs_s0_address != ADDR_LOCAL);
    s1_req_s  = (avs_s1_read | avs_s1_write) & (avs_s1_address != ADDR_LOCAL);
    s0_lrd_s  = avs_s0_read & (avs_s0_address == ADDR_LOCAL);
    s1_lrd_s  = avs_s1_read & (avs_s1_address == ADDR_LOCAL);
    fwd0_s    = (state_q == ST_OWN0) & s0_req_s;
    fwd1_s    = (state_q == ST_OWN1) & s1_req_s;
    grant_s   = {(state_q == ST_OWN1), (state_q == ST_OWN0)};
    if (fwd0_s) begin
      release_s = is_release(avs_s0_write, avs_s0_address, avs_s0_writedata);
    end else if (fwd1_s) begin
      release_s = is_release(avs_s1_write, avs_s1_address, avs_s1_writedata);
    end else begin
      release_s = 1'b0;
    end
  end

  // Next-state logic: arbitration in IDLE, release/timeout while owned
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = 16'd0;
        if (s0_req_s && s1_req_s) begin
          // Tie goes to whoever did not win the previous grant
          if (last_q) begin
            state_d = ST_OWN0;
            last_d  = 1'b0;
          end else begin
            state_d = ST_OWN1;
            last_d  = 1'b1;
          end
        end else if (s0_req_s) begin
          state_d = ST_OWN0;
          last_d  = 1'b0;
        end else if (s1_req_s) begin
          state_d = ST_OWN1;
          last_d  = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (fwd0_s || fwd1_s) begin
          cnt_d = 16'd0;
          if (release_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = state_q;
          end
        end else if (cnt_q >= CNT_LAST) begin
          // Owner went silent: take the slave back with a forced release
          cnt_d   = 16'd0;
          state_d = ST_FORCE;
        end else begin
          cnt_d   = cnt_q + 16'd1;
          state_d = state_q;
        end
      end
      ST_FORCE: begin
        cnt_d   = 16'd0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, round-robin history and idle counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      last_q  <= 1'b1;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Master-side mux: owner pass-through, forced release write, or all zeros
  always_comb begin
    avm_m0_address   = 2'd0;
    avm_m0_read      = 1'b0;
    avm_m0_write     = 1'b0;
    avm_m0_writedata = 32'd0;
    if (fwd0_s) begin
      avm_m0_address   = avs_s0_address;
      avm_m0_read      = avs_s0_read;
      avm_m0_write     = avs_s0_write;
      avm_m0_writedata = avs_s0_writedata;
    end else if (fwd1_s) begin
      avm_m0_address   = avs_s1_address;
      avm_m0_read      = avs_s1_read;
      avm_m0_write     = avs_s1_write;
      avm_m0_writedata = avs_s1_writedata;
    end else if (state_q == ST_FORCE) begin
      avm_m0_address   = ADDR_CTRL;
      avm_m0_write     = 1'b1;
      avm_m0_writedata = 32'h0000_0007;
    end else begin
      avm_m0_address   = 2'd0;
    end
  end

  // Requester-side read data and stalls; stalls drop while reset is held
  always_comb begin
    if (s0_lrd_s) begin
      avs_s0_readdata = {30'd0, grant_s};
    end else if (fwd0_s) begin
      avs_s0_readdata = avm_m0_readdata;
    end else begin
      avs_s0_readdata = 32'd0;
    end
    if (s1_lrd_s) begin
      avs_s1_readdata = {30'd0, grant_s};
    end else if (fwd1_s) begin
      avs_s1_readdata = avm_m0_readdata;
    end else begin
      avs_s1_readdata = 32'd0;
    end
    avs_s0_waitrequest = s0_req_s & ~fwd0_s & reset_n;
    avs_s1_waitrequest = s1_req_s & ~fwd1_s & reset_n;
    grant              = grant_s;
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed stimulus with a scoreboard. Expected completions and
// slave strobes are queued by the stimulus; a negedge monitor pops and compares.

module tb_spi_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avs_s0_address = 2'd0, avs_s1_address = 2'd0;
  logic        avs_s0_read = 1'b0, avs_s0_write = 1'b0;
  logic        avs_s1_read = 1'b0, avs_s1_write = 1'b0;
  logic [31:0] avs_s0_writedata = 32'd0, avs_s1_writedata = 32'd0;
  logic [31:0] avs_s0_readdata, avs_s1_readdata;
  logic        avs_s0_waitrequest, avs_s1_waitrequest;
  logic [1:0]  avm_m0_address;
  logic        avm_m0_read, avm_m0_write;
  logic [31:0] avm_m0_writedata;
  logic [31:0] avm_m0_readdata;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [1:0]  port;   // 0 = s0 completion, 1 = s1 completion, 2 = slave strobe
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] data;   // read data for reads, write data for slave writes
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  // Zero-wait slave model: read data encodes the address
  assign avm_m0_readdata = 32'hA5A5_0000 | {30'd0, avm_m0_address};

  spi_arbiter #(.TIMEOUT(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .avs_s0_address(avs_s0_address), .avs_s0_read(avs_s0_read),
    .avs_s0_write(avs_s0_write), .avs_s0_writedata(avs_s0_writedata),
    .avs_s0_readdata(avs_s0_readdata), .avs_s0_waitrequest(avs_s0_waitrequest),
    .avs_s1_address(avs_s1_address), .avs_s1_read(avs_s1_read),
    .avs_s1_write(avs_s1_write), .avs_s1_writedata(avs_s1_writedata),
    .avs_s1_readdata(avs_s1_readdata), .avs_s1_waitrequest(avs_s1_waitrequest),
    .avm_m0_address(avm_m0_address), .avm_m0_read(avm_m0_read),
    .avm_m0_write(avm_m0_write), .avm_m0_writedata(avm_m0_writedata),
    .avm_m0_readdata(avm_m0_readdata), .grant(grant)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] port, input logic wr, input logic [1:0] addr,
                      input logic [31:0] data);
    exp_t e;
    e.port = port; e.wr = wr; e.addr = addr; e.data = data;
    sb_q.push_back(e);
  endtask

  task automatic sb_match(input logic [1:0] port, input logic wr, input logic [1:0] addr,
                          input logic [31:0] data);
    exp_t e;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_errors++;
      $display("FAIL sb_unexpected: port %0d wr %0b addr %0d data %h, expected no event",
               port, wr, addr, data);
    end else begin
      e = sb_q.pop_front();
      if (e.port !== port || e.wr !== wr || e.addr !== addr || e.data !== data) begin
        n_errors++;
        $display("FAIL sb_event: got port %0d wr %0b addr %0d data %h, expected port %0d wr %0b addr %0d data %h",
                 port, wr, addr, data, e.port, e.wr, e.addr, e.data);
      end
    end
  endtask

  // Monitor: every completed requester access and every slave strobe
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if ((avs_s0_read | avs_s0_write) && !avs_s0_waitrequest)
        sb_match(2'd0, avs_s0_write, avs_s0_address, avs_s0_write ? 32'd0 : avs_s0_readdata);
      if ((avs_s1_read | avs_s1_write) && !avs_s1_waitrequest)
        sb_match(2'd1, avs_s1_write, avs_s1_address, avs_s1_write ? 32'd0 : avs_s1_readdata);
      if (avm_m0_read | avm_m0_write)
        sb_match(2'd2, avm_m0_write, avm_m0_address, avm_m0_write ? avm_m0_writedata : 32'd0);
    end
  end

  task automatic set0(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
    avs_s0_read = rd; avs_s0_write = wr; avs_s0_address = a; avs_s0_writedata = d;
  endtask

  task automatic set1(input logic rd, input logic wr, input logic [1:0] a, input logic [31:0] d);
    avs_s1_read = rd; avs_s1_write = wr; avs_s1_address = a; avs_s1_writedata = d;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] avm_vec();
    return {avm_m0_read, avm_m0_write, avm_m0_address} | avm_m0_writedata;
  endfunction

  initial begin
    // Reset state, with a request already present
    repeat (2) @(posedge clk);
    #1;
    set0(1'b1, 1'b0, 2'd0, 32'd0);
    #1;
    check("rst_wait0", 32'(avs_s0_waitrequest), 32'd0);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_avm", avm_vec(), 32'd0);
    set0(1'b0, 1'b0, 2'd0, 32'd0);
    reset_n = 1'b1;
    tick();

    // First tie after reset goes to s0, then alternates
    set0(1'b0, 1'b1, 2'd1, 32'h11);
    set1(1'b0, 1'b1, 2'd1, 32'h22);
    #1;
    check("tie1_wait0", 32'(avs_s0_waitrequest), 32'd1);
    check("tie1_wait1", 32'(avs_s1_waitrequest), 32'd1);
    tick();
    push(2'd0, 1'b1, 2'd1, 32'd0); push(2'd2, 1'b1, 2'd1, 32'h11);
    #1;
    check("tie1_grant", 32'(grant), 32'd1);
    check("tie1_nonowner_wait", 32'(avs_s1_waitrequest), 32'd1);
    tick();
    set0(1'b0, 1'b1, 2'd2, 32'h7);
    push(2'd0, 1'b1, 2'd2, 32'd0); push(2'd2, 1'b1, 2'd2, 32'h7);
    tick();
    set0(1'b0, 1'b0, 2'd0, 32'd0);
    #1;
    check("tie1_rel_grant", 32'(grant), 32'd0);
    check("tie1_rel_wait1", 32'(avs_s1_waitrequest), 32'd1);
    tick();
    push(2'd1, 1'b1, 2'd1, 32'd0); push(2'd2, 1'b1, 2'd1, 32'h22);
    #1;
    check("tie1_s1_grant", 32'(grant), 32'd2);
    tick();
    set1(1'b0, 1'b1, 2'd2, 32'h7);
    push(2'd1, 1'b1, 2'd2, 32'd0); push(2'd2, 1'b1, 2'd2, 32'h7);
    tick();
    set0(1'b0, 1'b1, 2'd1, 32'h33);
    set1(1'b0, 1'b1, 2'd1, 32'h44);
    tick();
    push(2'd0, 1'b1, 2'd1, 32'd0); push(2'd2, 1'b1, 2'd1, 32'h33);
    #1;
    check("tie2_grant", 32'(grant), 32'd1);
    tick();
    set0(1'b0, 1'b1, 2'd2, 32'h7);
    push(2'd0, 1'b1, 2'd2, 32'd0); push(2'd2, 1'b1, 2'd2, 32'h7);
    tick();
    set0(1'b0, 1'b0, 2'd0, 32'd0);
    tick();
    push(2'd1, 1'b1, 2'd1, 32'd0); push(2'd2, 1'b1, 2'd1, 32'h44);
    #1;
    check("tie2_s1_grant", 32'(grant), 32'd2);
    tick();
    set1(1'b0, 1'b1, 2'd2, 32'h7);
    push(2'd1, 1'b1, 2'd2, 32'd0); push(2'd2, 1'b1, 2'd2, 32'h7);
    tick();
    set1(1'b0, 1'b0, 2'd0, 32'd0);

    // Non-release write keeps ownership; data 0xF releases on its low bits
    set0(1'b0, 1'b1, 2'd2, 32'h6);
    #1;
    check("w6_stall", 32'(avs_s0_waitrequest), 32'd1);
    tick();
    push(2'd0, 1'b1, 2'd2, 32'd0); push(2'd2, 1'b1, 2'd2, 32'h6);
    #1;
    check("w6_grant", 32'(grant), 32'd1);
    tick();
    set0(1'b0, 1'b1, 2'd2, 32'hF);
    push(2'd0, 1'b1, 2'd2, 32'd0); push(2'd2, 1'b1, 2'd2, 32'hF);
    #1;
    check("w6_kept", 32'(grant), 32'd1);
    tick();
    set0(1'b0, 1'b0, 2'd0, 32'd0);
    #1;
    check("relF_grant", 32'(grant), 32'd0);
    tick();

    // Pending non-owner read waits for the owner's release
    set1(1'b1, 1'b0, 2'd0, 32'd0);
    tick();
    push(2'd1, 1'b0, 2'd0, 32'hA5A5_0000); push(2'd2, 1'b0, 2'd0, 32'd0);
    tick();
    set1(1'b0, 1'b0, 2'd0, 32'd0);
    set0(1'b1, 1'b0, 2'd0, 32'd0);
    #1;
    check("pend_wait0_a", 32'(avs_s0_waitrequest), 32'd1);
    check("pend_grant_s1", 32'(grant), 32'd2);
    check("pend_rdata0", avs_s0_readdata, 32'd0);
    tick();
    #1;
    check("pend_wait0_b", 32'(avs_s0_waitrequest), 32'd1);
    tick();
    set1(1'b0, 1'b1, 2'd2, 32'h7);
    push(2'd1, 1'b1, 2'd2, 32'd0); push(2'd2, 1'b1, 2'd2, 32'h7);
    #1;
    check("pend_wait0_c", 32'(avs_s0_waitrequest), 32'd1);
    tick();
    set1(1'b0, 1'b0, 2'd0, 32'd0);
    #1;
    check("pend_idle_grant", 32'(grant), 32'd0);
    check("pend_idle_wait0", 32'(avs_s0_waitrequest), 32'd1);
    tick();
    push(2'd0, 1'b0, 2'd0, 32'hA5A5_0000); push(2'd2, 1'b0, 2'd0, 32'd0);
    #1;
    check("pend_grant_s0", 32'(grant), 32'd1);
    tick();
    set0(1'b0, 1'b0, 2'd0, 32'd0);

    // s0 silent for 8 cycles; first of them carries a local status read from s1
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        set1(1'b1, 1'b0, 2'd3, 32'd0);
        push(2'd1, 1'b0, 2'd3, 32'h1);
        #1;
        check("a3_wait1", 32'(avs_s1_waitrequest), 32'd0);
      end else begin
        set1(1'b0, 1'b0, 2'd0, 32'd0);
      end
      #1;
      check("to_hold_grant", 32'(grant), 32'd1);
      tick();
    end
    set0(1'b1, 1'b0, 2'd1, 32'd0);
    push(2'd2, 1'b1, 2'd2, 32'h7);
    #1;
    check("force_grant", 32'(grant), 32'd0);
    check("force_wait0", 32'(avs_s0_waitrequest), 32'd1);
    tick();
    #1;
    check("after_force_grant", 32'(grant), 32'd0);
    tick();
    push(2'd0, 1'b0, 2'd1, 32'hA5A5_0001); push(2'd2, 1'b0, 2'd1, 32'd0);
    tick();

    // Asynchronous reset while s0 owns and s1 is pending
    set0(1'b1, 1'b0, 2'd0, 32'd0);
    set1(1'b1, 1'b0, 2'd1, 32'd0);
    #1;
    check("prerst_grant", 32'(grant), 32'd1);
    check("prerst_wait1", 32'(avs_s1_waitrequest), 32'd1);
    reset_n = 1'b0;
    #1;
    check("arst_grant", 32'(grant), 32'd0);
    check("arst_avm", avm_vec(), 32'd0);
    check("arst_wait0", 32'(avs_s0_waitrequest), 32'd0);
    check("arst_wait1", 32'(avs_s1_waitrequest), 32'd0);
    set0(1'b0, 1'b0, 2'd0, 32'd0);
    set1(1'b0, 1'b0, 2'd0, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("postrst_grant", 32'(grant), 32'd0);
    end

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
